global_mem_arbiter: RTL and testbench
=====================================

GLOBAL_MEM_ARBITER -- requirements
Module: global_mem_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requester ports.
REQ-002 Parameter N_BANKS, default 4 (power of 2): number of global memory banks.
REQ-003 Parameter DATA_L, default 32: data width.
REQ-004 Parameter BANK_ADDR_L, default 10: per-bank word address width.
REQ-005 Parameter RD_LATENCY, default 2: bank read latency in cycles, rd_en cycle to rd_data valid.
REQ-006 Parameter IDLE_SLP_CYCLES, default 16: consecutive idle cycles before a bank enters sleep.
REQ-007 Clocking and reset: one clock; reset is synchronous and active-low.
REQ-008 clk  in  1  clock; all state updates on the rising edge.
REQ-009 rst  in  1  synchronous, active-low reset.
REQ-010 cfg_slp_en  in  1  enables automatic bank sleep.
REQ-011 req_valid  in  N_REQ  request valid per requester.
REQ-012 req_wr  in  N_REQ  1 = write, 0 = read.
REQ-013 req_addr  in  N_REQ x (log2(N_BANKS)+BANK_ADDR_L)  low log2(N_BANKS) bits = bank, upper bits = word address.
REQ-014 req_wr_data  in  N_REQ x DATA_L  write data.
REQ-015 req_ready  out  N_REQ  request accepted this cycle.
REQ-016 rsp_valid  out  N_REQ  read data valid.
REQ-017 rsp_data  out  N_REQ x DATA_L  read data.
REQ-018 global_mem_addr / _wr_data / _wr_en / _rd_en  out  per bank: BANK_ADDR_L / DATA_L / 1 / 1  bank command.
REQ-019 global_mem_rd_data  in  N_BANKS x DATA_L  bank read data.
REQ-020 config_global_mem_slp  out  N_BANKS  bank sleep control.

Function
REQ-021 Transfer occurs when req_valid[i] and req_ready[i] are both 1; req_ready is combinational from current request and state, with no extra cycle.
REQ-022 Per bank, round-robin among requesters targeting it: search starts at last-granted index +1 and wraps; the pointer updates only on a grant.
REQ-023 At most one grant per bank per cycle; each requester addresses one bank, so it gets at most one grant per cycle.
REQ-024 Granted bank outputs in the same cycle: addr = winner word address, wr_en = req_wr, rd_en = !req_wr, wr_data = winner data; without a grant, wr_en = rd_en = 0 and addr/wr_data = 0.
REQ-025 A granted read shall assert rsp_valid[i] exactly RD_LATENCY cycles after the grant cycle, with rsp_data[i] = global_mem_rd_data[bank] in that cycle.
REQ-026 Read tracking: a per-bank RD_LATENCY-deep shift pipeline of {valid, requester id}.
REQ-027 rsp_data = 0 when rsp_valid = 0.
REQ-028 Writes produce no response.
REQ-029 Bank FSM states ACTIVE, SLEEP, WAKE.
REQ-030 ACTIVE: the idle counter increments (saturating at IDLE_SLP_CYCLES) on cycles with no grant and an empty read pipeline, else clears to 0; ACTIVE -> SLEEP when counter == IDLE_SLP_CYCLES and cfg_slp_en = 1.
REQ-031 SLEEP: slp = 1, no grants (req_ready = 0 for that bank); SLEEP -> WAKE on any valid request to the bank or cfg_slp_en = 0.
REQ-032 WAKE: slp = 0, no grants, lasts exactly 1 cycle, then -> ACTIVE with counter = 0.
REQ-033 cfg_slp_en dropping in ACTIVE only stops entry to SLEEP; the counter keeps counting.
REQ-034 Simultaneous idle-threshold and new request: a request in the threshold cycle is granted and blocks sleep entry (counter clears).

Reset
REQ-035 While rst = 0 at a clock edge: all FSMs -> ACTIVE, idle counters = 0, RR pointers = N_REQ-1 (requester 0 wins first), read pipelines cleared.
REQ-036 Outputs are combinational from that state and the current inputs; during and immediately after reset, rsp_valid = 0, slp = 0, rsp_data = 0, and wr_en/rd_en = 0.
REQ-037 During reset, req_ready = 0, no grants and no bank commands regardless of inputs.
REQ-038 Reset asserted mid-read drops in-flight responses; no rsp_valid after reset release for pre-reset reads.

Verification
REQ-039 Contention: req 0,1,2 read bank 1 every cycle -> grants 0,1,2,0,1,2; each rsp_valid exactly 2 cycles after its grant, with the matching data.
REQ-040 Parallel banks: req0 writes bank0 addr 5 = 0xA5A5A5A5 while req1 writes bank1 at the same time -> both ready in the same cycle; a later read of bank0 addr 5 returns 0xA5A5A5A5.
REQ-041 Sleep: cfg_slp_en = 1, no traffic for 16 cycles -> slp[b] = 1 on cycle 17 for all banks; with cfg_slp_en = 0 -> slp stays 0.
REQ-042 Wake: bank2 asleep, req3 reads bank2 -> slp = 0 next cycle (WAKE, ready = 0), grant the following cycle, rsp_valid 2 cycles later.
REQ-043 Threshold race: a request arrives in the cycle the counter reaches 16 -> granted, slp stays 0.
REQ-044 Reset mid-read: rst = 0 one cycle after a read grant -> no rsp_valid; all outputs 0 and slp = 0.

Source files
------------

// File: rtl/global_mem_arbiter_if.sv
// rtl/global_mem_arbiter_if.sv - requester/bank bus bundle for the global memory arbiter
interface global_mem_arbiter_if #(
  parameter int N_REQ       = 4,
  parameter int N_BANKS     = 4,
  parameter int DATA_L      = 32,
  parameter int BANK_ADDR_L = 10
) ();
  localparam int AW = $clog2(N_BANKS) + BANK_ADDR_L;

  logic [N_REQ-1:0]                    req_valid;
  logic [N_REQ-1:0]                    req_wr;
  logic [N_REQ-1:0][AW-1:0]            req_addr;
  logic [N_REQ-1:0][DATA_L-1:0]        req_wr_data;
  logic [N_REQ-1:0]                    req_ready;
  logic [N_REQ-1:0]                    rsp_valid;
  logic [N_REQ-1:0][DATA_L-1:0]        rsp_data;
  logic [N_BANKS-1:0][BANK_ADDR_L-1:0] global_mem_addr;
  logic [N_BANKS-1:0][DATA_L-1:0]      global_mem_wr_data;
  logic [N_BANKS-1:0]                  global_mem_wr_en;
  logic [N_BANKS-1:0]                  global_mem_rd_en;
  logic [N_BANKS-1:0][DATA_L-1:0]      global_mem_rd_data;
  logic [N_BANKS-1:0]                  config_global_mem_slp;

  modport slave (
    input  req_valid, req_wr, req_addr, req_wr_data, global_mem_rd_data,
    output req_ready, rsp_valid, rsp_data, global_mem_addr, global_mem_wr_data,
           global_mem_wr_en, global_mem_rd_en, config_global_mem_slp
  );

  modport master (
    output req_valid, req_wr, req_addr, req_wr_data, global_mem_rd_data,
    input  req_ready, rsp_valid, rsp_data, global_mem_addr, global_mem_wr_data,
           global_mem_wr_en, global_mem_rd_en, config_global_mem_slp
  );
endinterface

// File: rtl/global_mem_arbiter.sv
// rtl/global_mem_arbiter.sv - per-bank round-robin arbiter with read tracking and idle sleep
module global_mem_arbiter #(
  parameter int N_REQ           = 4,
  parameter int N_BANKS         = 4,
  parameter int DATA_L          = 32,
  parameter int BANK_ADDR_L     = 10,
  parameter int RD_LATENCY      = 2,
  parameter int IDLE_SLP_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_slp_en,
  global_mem_arbiter_if.slave  bus
);
  localparam int BANK_L = $clog2(N_BANKS);
  localparam int AW     = BANK_L + BANK_ADDR_L;
  localparam int ID_L   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_L  = $clog2(IDLE_SLP_CYCLES + 1);
  localparam logic [CNT_L-1:0] CNT_MAX = CNT_L'(IDLE_SLP_CYCLES);

  typedef enum logic [1:0] {
    ST_ACTIVE = 2'd0,
    ST_SLEEP  = 2'd1,
    ST_WAKE   = 2'd2
  } bank_st_e;

  bank_st_e               state_q    [N_BANKS];
  logic [CNT_L-1:0]       idle_cnt_q [N_BANKS];
  logic [ID_L-1:0]        rr_ptr_q   [N_BANKS];
  logic [RD_LATENCY-1:0]  pipe_vld_q [N_BANKS];
  logic [ID_L-1:0]        pipe_id_q  [N_BANKS][RD_LATENCY];
  logic [N_BANKS-1:0]     slp_q;

  logic [N_BANKS-1:0][N_REQ-1:0] bank_req;
  logic [N_BANKS-1:0]            gnt_vld;
  logic [ID_L-1:0]               gnt_id [N_BANKS];
  logic [N_BANKS-1:0]            bank_busy;

  always_comb begin : req_decode
    bank_req = '0;
    for (int i = 0; i < N_REQ; i++) begin
      for (int b = 0; b < N_BANKS; b++) begin
        if (bus.req_valid[i] && (bus.req_addr[i][BANK_L-1:0] == BANK_L'(b))) begin
          bank_req[b][i] = 1'b1;
        end
      end
    end
  end

  // Search begins one past the last winner so every requester gets its turn.
  always_comb begin : rr_pick
    int idx;
    idx       = 0;
    gnt_vld   = '0;
    bank_busy = '0;
    for (int b = 0; b < N_BANKS; b++) begin
      gnt_id[b] = '0;
      if (rst && (state_q[b] == ST_ACTIVE)) begin
        for (int k = 0; k < N_REQ; k++) begin
          idx = int'(rr_ptr_q[b]) + 1 + k;
          if (idx >= N_REQ) begin
            idx = idx - N_REQ;
          end
          if (!gnt_vld[b] && bank_req[b][ID_L'(idx)]) begin
            gnt_vld[b] = 1'b1;
            gnt_id[b]  = ID_L'(idx);
          end
        end
      end
      bank_busy[b] = gnt_vld[b] || (|pipe_vld_q[b]);
    end
  end

  always_comb begin : drive_out
    bus.req_ready          = '0;
    bus.global_mem_addr    = '0;
    bus.global_mem_wr_data = '0;
    bus.global_mem_wr_en   = '0;
    bus.global_mem_rd_en   = '0;
    bus.rsp_valid          = '0;
    bus.rsp_data           = '0;
    for (int b = 0; b < N_BANKS; b++) begin
      if (gnt_vld[b]) begin
        bus.req_ready[gnt_id[b]]  = 1'b1;
        bus.global_mem_addr[b]    = bus.req_addr[gnt_id[b]][AW-1:BANK_L];
        bus.global_mem_wr_data[b] = bus.req_wr_data[gnt_id[b]];
        bus.global_mem_wr_en[b]   = bus.req_wr[gnt_id[b]];
        bus.global_mem_rd_en[b]   = !bus.req_wr[gnt_id[b]];
      end
      // A requester owns at most one bank per cycle, so lanes never collide.
      if (rst && pipe_vld_q[b][RD_LATENCY-1]) begin
        bus.rsp_valid[pipe_id_q[b][RD_LATENCY-1]] = 1'b1;
        bus.rsp_data[pipe_id_q[b][RD_LATENCY-1]]  = bus.global_mem_rd_data[b];
      end
    end
    bus.config_global_mem_slp = rst ? slp_q : '0;
  end

  always_ff @(posedge clk) begin : bank_fsm
    for (int b = 0; b < N_BANKS; b++) begin
      if (!rst) begin
        state_q[b]    <= ST_ACTIVE;
        idle_cnt_q[b] <= '0;
        rr_ptr_q[b]   <= ID_L'(N_REQ - 1);
        pipe_vld_q[b] <= '0;
        slp_q[b]      <= 1'b0;
        for (int s = 0; s < RD_LATENCY; s++) begin
          pipe_id_q[b][s] <= '0;
        end
      end else begin
        if (gnt_vld[b]) begin
          rr_ptr_q[b] <= gnt_id[b];
        end
        pipe_vld_q[b][0] <= gnt_vld[b] && !bus.req_wr[gnt_id[b]];
        pipe_id_q[b][0]  <= gnt_id[b];
        for (int s = 1; s < RD_LATENCY; s++) begin
          pipe_vld_q[b][s] <= pipe_vld_q[b][s-1];
          pipe_id_q[b][s]  <= pipe_id_q[b][s-1];
        end
        case (state_q[b])
          ST_ACTIVE: begin
            if (bank_busy[b]) begin
              idle_cnt_q[b] <= '0;
            end else if (idle_cnt_q[b] != CNT_MAX) begin
              idle_cnt_q[b] <= idle_cnt_q[b] + 1'b1;
            end
            // A grant in the threshold cycle keeps the bank awake.
            if (!bank_busy[b] && (idle_cnt_q[b] == CNT_MAX) && cfg_slp_en) begin
              state_q[b] <= ST_SLEEP;
              slp_q[b]   <= 1'b1;
            end
          end
          ST_SLEEP: begin
            if ((|bank_req[b]) || !cfg_slp_en) begin
              state_q[b] <= ST_WAKE;
              slp_q[b]   <= 1'b0;
            end
          end
          ST_WAKE: begin
            state_q[b]    <= ST_ACTIVE;
            idle_cnt_q[b] <= '0;
          end
          default: begin
            state_q[b] <= ST_ACTIVE;
            slp_q[b]   <= 1'b0;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_global_mem_arbiter.sv
// tb/tb_global_mem_arbiter.sv - directed-vector bench for global_mem_arbiter
module tb_global_mem_arbiter;
  logic clk;
  logic rst;
  logic cfg_slp_en;
  int   n_vec;
  int   n_miss;

  global_mem_arbiter_if #(.N_REQ(4), .N_BANKS(4), .DATA_L(32), .BANK_ADDR_L(10)) bus ();

  global_mem_arbiter #(
    .N_REQ(4), .N_BANKS(4), .DATA_L(32), .BANK_ADDR_L(10),
    .RD_LATENCY(2), .IDLE_SLP_CYCLES(16)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_slp_en (cfg_slp_en),
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bank model: unwritten words read back a fixed pattern, two-cycle read latency.
  bit [31:0] mem     [4][1024];
  bit        written [4][1024];
  bit [31:0] rd_s0   [4];
  bit [31:0] rd_s1   [4];

  function automatic bit [31:0] pat(input int b, input int a);
    return 32'hC0DE_0000 | (b << 12) | a;
  endfunction

  always @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (bus.global_mem_wr_en[b]) begin
        mem[b][bus.global_mem_addr[b]]     <= bus.global_mem_wr_data[b];
        written[b][bus.global_mem_addr[b]] <= 1'b1;
      end
      if (bus.global_mem_rd_en[b]) begin
        rd_s0[b] <= written[b][bus.global_mem_addr[b]] ? mem[b][bus.global_mem_addr[b]]
                                                       : pat(b, int'(bus.global_mem_addr[b]));
      end else begin
        rd_s0[b] <= 32'h0;
      end
      rd_s1[b] <= rd_s0[b];
    end
  end

  always_comb begin
    for (int b = 0; b < 4; b++) begin
      bus.global_mem_rd_data[b] = rd_s1[b];
    end
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input bit wr, input int bank, input int word,
                         input logic [31:0] data);
    bus.req_valid[i[1:0]]   = 1'b1;
    bus.req_wr[i[1:0]]      = wr;
    bus.req_addr[i[1:0]]    = 12'((word << 2) | bank);
    bus.req_wr_data[i[1:0]] = data;
  endtask

  task automatic clear_reqs();
    bus.req_valid   = '0;
    bus.req_wr      = '0;
    bus.req_addr    = '0;
    bus.req_wr_data = '0;
  endtask

  task automatic do_reset();
    clear_reqs();
    rst = 1'b0;
    repeat (3) step();
    rst = 1'b1;
  endtask

  function automatic logic [127:0] lane(input int i, input logic [31:0] v);
    logic [127:0] r;
    r = '0;
    r[i*32 +: 32] = v;
    return r;
  endfunction

  int               gnt_ord [6] = '{0, 1, 2, 0, 1, 2};
  logic [31:0]      cont_dat [3] = '{32'hC0DE_1010, 32'hC0DE_1011, 32'hC0DE_1012};

  initial begin
    n_vec      = 0;
    n_miss     = 0;
    rst        = 1'b0;
    cfg_slp_en = 1'b0;
    clear_reqs();

    // Reset with every requester shouting at bank 0.
    for (int i = 0; i < 4; i++) set_req(i, 1'b0, 0, i, 32'h0);
    repeat (3) step();
    #2;
    check("rst_ready", bus.req_ready, 4'b0000);
    check("rst_rd_en", bus.global_mem_rd_en, 4'b0000);
    check("rst_wr_en", bus.global_mem_wr_en, 4'b0000);
    check("rst_rsp_valid", bus.rsp_valid, 4'b0000);
    check("rst_rsp_data", bus.rsp_data, 128'h0);
    check("rst_slp", bus.config_global_mem_slp, 4'b0000);
    step();
    clear_reqs();
    rst = 1'b1;
    #2;
    check("post_rst_rsp_valid", bus.rsp_valid, 4'b0000);
    check("post_rst_slp", bus.config_global_mem_slp, 4'b0000);
    step();

    // Contention on bank 1.
    for (int k = 0; k < 8; k++) begin
      clear_reqs();
      if (k < 6) for (int i = 0; i < 3; i++) set_req(i, 1'b0, 1, 16 + i, 32'h0);
      #2;
      if (k < 6) begin
        check($sformatf("cont_ready_%0d", k), bus.req_ready, 4'(1 << gnt_ord[k]));
        check($sformatf("cont_rd_en_%0d", k), bus.global_mem_rd_en, 4'b0010);
        check($sformatf("cont_addr_%0d", k), bus.global_mem_addr[1], 16 + gnt_ord[k]);
      end
      if (k >= 2) begin
        check($sformatf("cont_rsp_valid_%0d", k), bus.rsp_valid, 4'(1 << gnt_ord[k-2]));
        check($sformatf("cont_rsp_data_%0d", k), bus.rsp_data,
              lane(gnt_ord[k-2], cont_dat[gnt_ord[k-2]]));
      end else begin
        check($sformatf("cont_rsp_valid_%0d", k), bus.rsp_valid, 4'b0000);
      end
      step();
    end

    // Parallel writes to banks 0 and 1, then read bank 0 back.
    clear_reqs();
    set_req(0, 1'b1, 0, 5, 32'hA5A5_A5A5);
    set_req(1, 1'b1, 1, 7, 32'hDEAD_BEEF);
    #2;
    check("par_ready", bus.req_ready, 4'b0011);
    check("par_wr_en", bus.global_mem_wr_en, 4'b0011);
    check("par_rd_en", bus.global_mem_rd_en, 4'b0000);
    check("par_addr0", bus.global_mem_addr[0], 10'd5);
    check("par_addr1", bus.global_mem_addr[1], 10'd7);
    check("par_wdata0", bus.global_mem_wr_data[0], 32'hA5A5_A5A5);
    check("par_wdata1", bus.global_mem_wr_data[1], 32'hDEAD_BEEF);
    step();
    clear_reqs();
    step();
    set_req(2, 1'b0, 0, 5, 32'h0);
    #2;
    check("rb_ready", bus.req_ready, 4'b0100);
    check("rb_rd_en", bus.global_mem_rd_en, 4'b0001);
    step();
    clear_reqs();
    #2;
    check("rb_rsp_early", bus.rsp_valid, 4'b0000);
    step();
    #2;
    check("rb_rsp_valid", bus.rsp_valid, 4'b0100);
    check("rb_rsp_data", bus.rsp_data, lane(2, 32'hA5A5_A5A5));
    step();
    #2;
    check("wr_no_rsp", bus.rsp_valid, 4'b0000);

    // Sleep disabled: long idle never sleeps.
    repeat (40) step();
    #2;
    check("nosleep_slp", bus.config_global_mem_slp, 4'b0000);

    // Sleep enabled: 16 idle edges keep slp low, the 17th raises it.
    cfg_slp_en = 1'b1;
    do_reset();
    repeat (16) step();
    #2;
    check("sleep_edge16", bus.config_global_mem_slp, 4'b0000);
    step();
    #2;
    check("sleep_edge17", bus.config_global_mem_slp, 4'b1111);

    // Wake bank 2 with a read from requester 3.
    set_req(3, 1'b0, 2, 9, 32'h0);
    #2;
    check("wake_sleep_ready", bus.req_ready, 4'b0000);
    step();
    #2;
    check("wake_slp", bus.config_global_mem_slp, 4'b1011);
    check("wake_ready", bus.req_ready, 4'b0000);
    step();
    #2;
    check("wake_grant", bus.req_ready, 4'b1000);
    check("wake_rd_en", bus.global_mem_rd_en, 4'b0100);
    check("wake_addr", bus.global_mem_addr[2], 10'd9);
    step();
    clear_reqs();
    #2;
    check("wake_rsp_early", bus.rsp_valid, 4'b0000);
    step();
    #2;
    check("wake_rsp_valid", bus.rsp_valid, 4'b1000);
    check("wake_rsp_data", bus.rsp_data, lane(3, 32'hC0DE_2009));
    cfg_slp_en = 1'b0;
    step();
    #2;
    check("cfg_off_wake", bus.config_global_mem_slp, 4'b0000);

    // Request lands in the threshold cycle of bank 0.
    cfg_slp_en = 1'b1;
    do_reset();
    repeat (16) step();
    set_req(0, 1'b0, 0, 3, 32'h0);
    #2;
    check("race_ready", bus.req_ready, 4'b0001);
    step();
    clear_reqs();
    #2;
    check("race_slp", bus.config_global_mem_slp, 4'b1110);
    step();
    #2;
    check("race_rsp_valid", bus.rsp_valid, 4'b0001);
    check("race_rsp_data", bus.rsp_data, lane(0, 32'hC0DE_0003));

    // Reset one cycle after a read grant drops the response.
    cfg_slp_en = 1'b0;
    do_reset();
    set_req(0, 1'b0, 1, 4, 32'h0);
    #2;
    check("mid_ready", bus.req_ready, 4'b0001);
    step();
    clear_reqs();
    rst = 1'b0;
    #2;
    check("mid_rst_rsp", bus.rsp_valid, 4'b0000);
    step();
    rst = 1'b1;
    #2;
    check("mid_after_rsp", bus.rsp_valid, 4'b0000);
    check("mid_after_data", bus.rsp_data, 128'h0);
    step();
    #2;
    check("mid_late_rsp", bus.rsp_valid, 4'b0000);
    check("mid_slp", bus.config_global_mem_slp, 4'b0000);
    check("mid_rd_en", bus.global_mem_rd_en, 4'b0000);
    check("mid_wr_en", bus.global_mem_wr_en, 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
